// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: fetch/decode/exec/mem/wb sequencing,
// datapath strobes, alu_op, mem_ready watchdog, retired count.
module multicycle_main_control #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_source,
  output logic             illegal_instr,
  output logic             mem_fault,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR  = 4'd2;
  localparam logic [3:0] S_MRD    = 4'd3;
  localparam logic [3:0] S_MWB    = 4'd4;
  localparam logic [3:0] S_MWR    = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_AWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam int WW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  localparam logic [WW-1:0] W1  = WW'(1);
  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);

  logic [3:0]    state;
  logic [3:0]    nxt;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_d;
  logic          waiting;
  logic          expired;
  logic          retire;
  logic          set_ill;
  logic          pw_c, iw_c, mr_c, mw_c, rw_c;

  assign waiting = (state == S_FETCH) ||
                   (state == S_MRD)   ||
                   (state == S_MWR);

  // Counter already at the limit and memory
  // still not ready this cycle: give up.
  assign expired = (TIMEOUT != 0) && waiting &&
                   !mem_ready && (wcnt == TMO);

  always_comb begin
    nxt        = state;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 1'b0;
    pw_c       = 1'b0;
    iw_c       = 1'b0;
    mr_c       = 1'b0;
    mw_c       = 1'b0;
    rw_c       = 1'b0;
    retire     = 1'b0;
    set_ill    = 1'b0;
    case (state)
      S_FETCH: begin
        mr_c      = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          iw_c = 1'b1;
          pw_c = 1'b1;
          nxt  = S_DECODE;
        end else if (expired) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        unique case (1'b1)
          (opcode == OP_R):  nxt = S_EXEC;
          (opcode == OP_LD),
          (opcode == OP_ST): nxt = S_MADDR;
          (opcode == OP_BR): nxt = S_BRANCH;
          default: begin
            nxt     = S_TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      S_MADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        nxt = (opcode == OP_ST) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mr_c = 1'b1;
        iord = 1'b1;
        if (mem_ready)    nxt = S_MWB;
        else if (expired) nxt = S_TRAP;
      end
      S_MWB: begin
        rw_c       = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = S_FETCH;
        retire     = 1'b1;
      end
      S_MWR: begin
        mw_c = 1'b1;
        iord = 1'b1;
        if (mem_ready) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end else if (expired) begin
          nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        nxt       = S_AWB;
      end
      S_AWB: begin
        rw_c   = 1'b1;
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_source = 1'b1;
        pw_c      = zero;
        nxt       = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  // Clears on entry (state change), on ready,
  // outside wait states, or when disabled.
  always_comb begin
    wcnt_d = '0;
    if (waiting && !mem_ready &&
        (nxt == state) && (TIMEOUT != 0))
      wcnt_d = wcnt + W1;
  end

  assign pc_write  = pw_c & ~rst;
  assign ir_write  = iw_c & ~rst;
  assign mem_read  = mr_c & ~rst;
  assign mem_write = mw_c & ~rst;
  assign reg_write = rw_c & ~rst;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      wcnt          <= '0;
      retired       <= '0;
      illegal_instr <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      state <= nxt;
      wcnt  <= wcnt_d;
      if (retire)  retired       <= retired + C1;
      if (set_ill) illegal_instr <= 1'b1;
      if (expired) mem_fault     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: vector table
// plus watchdog, reset-abort and counter-wrap sequences.
module tb_multicycle_main_control;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] IL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, iord;
  logic       mem_read, mem_write, reg_write;
  logic       mem_to_reg, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       illegal_instr, mem_fault;
  logic [3:0] state_dbg;
  logic [3:0] retired;

  multicycle_main_control #(
    .TIMEOUT(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .ir_write(ir_write),
    .iord(iord),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_source(pc_source),
    .illegal_instr(illegal_instr),
    .mem_fault(mem_fault),
    .state_dbg(state_dbg),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [13:0] act_ctl;
  assign act_ctl = {pc_write, ir_write, iord,
                    mem_read, mem_write, reg_write,
                    mem_to_reg, alu_src_a, alu_src_b,
                    alu_op, pc_source};

  typedef struct {
    logic        rdy;
    logic [6:0]  opc;
    logic        z;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [3:0]  ret;
    logic        ill;
  } vec_t;

  vec_t tbl [30];
  int total = 0;
  int bad   = 0;

  logic [13:0] C_FR, C_FW, C_RST, C_DEC, C_MA;
  logic [13:0] C_MRD, C_MWB, C_MWR, C_EX, C_AWB;
  logic [13:0] C_BR1, C_BR0, C_0;

  function automatic logic [13:0] mk(
    logic pw, logic iw, logic io, logic mr,
    logic mw, logic rw, logic m2r,
    logic [1:0] a, logic [1:0] b,
    logic [1:0] op, logic ps);
    return {pw, iw, io, mr, mw, rw, m2r,
            a, b, op, ps};
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [6:0] o,
                       logic z);
    @(negedge clk);
    mem_ready = r;
    opcode    = o;
    zero      = z;
    #1;
  endtask

  task automatic put(int i, logic r,
                     logic [6:0] o, logic z,
                     logic [3:0] s,
                     logic [13:0] c,
                     logic [3:0] rt, logic il);
    tbl[i] = '{r, o, z, s, c, rt, il};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    C_FR  = mk(1,1,0,1,0,0,0,2'b00,2'b01,2'b00,0);
    C_FW  = mk(0,0,0,1,0,0,0,2'b00,2'b01,2'b00,0);
    C_RST = mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,0);
    C_DEC = mk(0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0);
    C_MA  = mk(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,0);
    C_MRD = mk(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,0);
    C_MWB = mk(0,0,0,0,0,1,1,2'b00,2'b00,2'b00,0);
    C_MWR = mk(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0);
    C_EX  = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b10,0);
    C_AWB = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    C_BR1 = mk(1,0,0,0,0,0,0,2'b01,2'b00,2'b01,1);
    C_BR0 = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b01,1);
    C_0   = 14'd0;

    put( 0,1,R ,0,4'd0 ,C_FR ,4'd0,0);
    put( 1,1,R ,0,4'd1 ,C_DEC,4'd0,0);
    put( 2,1,R ,0,4'd6 ,C_EX ,4'd0,0);
    put( 3,1,R ,0,4'd7 ,C_AWB,4'd0,0);
    put( 4,1,LD,0,4'd0 ,C_FR ,4'd1,0);
    put( 5,1,LD,0,4'd1 ,C_DEC,4'd1,0);
    put( 6,1,LD,0,4'd2 ,C_MA ,4'd1,0);
    put( 7,1,LD,0,4'd3 ,C_MRD,4'd1,0);
    put( 8,1,LD,0,4'd4 ,C_MWB,4'd1,0);
    put( 9,1,ST,0,4'd0 ,C_FR ,4'd2,0);
    put(10,1,ST,0,4'd1 ,C_DEC,4'd2,0);
    put(11,1,ST,0,4'd2 ,C_MA ,4'd2,0);
    put(12,1,ST,0,4'd5 ,C_MWR,4'd2,0);
    put(13,1,BR,1,4'd0 ,C_FR ,4'd3,0);
    put(14,1,BR,1,4'd1 ,C_DEC,4'd3,0);
    put(15,1,BR,1,4'd8 ,C_BR1,4'd3,0);
    put(16,1,BR,0,4'd0 ,C_FR ,4'd4,0);
    put(17,1,BR,0,4'd1 ,C_DEC,4'd4,0);
    put(18,1,BR,0,4'd8 ,C_BR0,4'd4,0);
    put(19,0,R ,0,4'd0 ,C_FW ,4'd5,0);
    put(20,0,R ,0,4'd0 ,C_FW ,4'd5,0);
    put(21,0,R ,0,4'd0 ,C_FW ,4'd5,0);
    put(22,1,R ,0,4'd0 ,C_FR ,4'd5,0);
    put(23,1,R ,0,4'd1 ,C_DEC,4'd5,0);
    put(24,1,R ,0,4'd6 ,C_EX ,4'd5,0);
    put(25,1,R ,0,4'd7 ,C_AWB,4'd5,0);
    put(26,1,IL,0,4'd0 ,C_FR ,4'd6,0);
    put(27,1,IL,0,4'd1 ,C_DEC,4'd6,0);
    put(28,1,IL,0,4'd15,C_0  ,4'd6,1);
    put(29,1,IL,0,4'd15,C_0  ,4'd6,1);

    rst       = 1'b1;
    opcode    = R;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    drive(1, R, 0);
    chk("rst state", 32'(state_dbg), 32'd0);
    chk("rst ctl", 32'(act_ctl), 32'(C_RST));
    chk("rst retired", 32'(retired), 32'd0);
    chk("rst ill", 32'(illegal_instr), 32'd0);
    chk("rst flt", 32'(mem_fault), 32'd0);
    mem_ready = 1'b0;
    rst       = 1'b0;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].rdy, tbl[i].opc, tbl[i].z);
      chk($sformatf("v%0d state", i),
          32'(state_dbg), 32'(tbl[i].st));
      chk($sformatf("v%0d ctl", i),
          32'(act_ctl), 32'(tbl[i].ctl));
      chk($sformatf("v%0d retired", i),
          32'(retired), 32'(tbl[i].ret));
      chk($sformatf("v%0d ill", i),
          32'(illegal_instr), 32'(tbl[i].ill));
      chk($sformatf("v%0d flt", i),
          32'(mem_fault), 32'd0);
    end

    // reset out of TRAP
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("trap rst pw", 32'(pc_write), 32'd0);
    @(posedge clk);
    #1;
    chk("trap rst state", 32'(state_dbg), 32'd0);
    chk("trap rst ill", 32'(illegal_instr), 32'd0);
    chk("trap rst ret", 32'(retired), 32'd0);
    chk("trap rst mrd", 32'(mem_read), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;

    // watchdog expiry in MEM_RD
    do_reset();
    drive(1, LD, 0);
    drive(1, LD, 0);
    drive(1, LD, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, LD, 0);
      chk($sformatf("wd%0d state", k),
          32'(state_dbg), 32'd3);
      chk($sformatf("wd%0d flt", k),
          32'(mem_fault), 32'd0);
    end
    drive(0, LD, 0);
    chk("wd trap state", 32'(state_dbg), 32'd15);
    chk("wd trap flt", 32'(mem_fault), 32'd1);
    chk("wd trap ill", 32'(illegal_instr), 32'd0);
    chk("wd trap ctl", 32'(act_ctl), 32'(C_0));

    // ready on the limit cycle wins
    do_reset();
    drive(1, LD, 0);
    drive(1, LD, 0);
    drive(1, LD, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, LD, 0);
      chk($sformatf("rw%0d state", k),
          32'(state_dbg), 32'd3);
    end
    drive(1, LD, 0);
    chk("rw edge state", 32'(state_dbg), 32'd3);
    drive(1, LD, 0);
    chk("rw wb state", 32'(state_dbg), 32'd4);
    chk("rw wb flt", 32'(mem_fault), 32'd0);

    // reset in the middle of a store
    do_reset();
    drive(1, ST, 0);
    drive(1, ST, 0);
    drive(1, ST, 0);
    drive(0, ST, 0);
    chk("mwr state", 32'(state_dbg), 32'd5);
    chk("mwr mw", 32'(mem_write), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mwr rst mw", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    chk("mwr ab state", 32'(state_dbg), 32'd0);
    chk("mwr ab mw", 32'(mem_write), 32'd0);
    chk("mwr ab mrd", 32'(mem_read), 32'd0);
    chk("mwr ab ret", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // retired counter wraps at 16
    do_reset();
    for (int n = 0; n < 16; n++) begin
      drive(1, R, 0);
      if (n == 15)
        chk("wrap 15", 32'(retired), 32'd15);
      drive(1, R, 0);
      drive(1, R, 0);
      drive(1, R, 0);
    end
    drive(1, R, 0);
    chk("wrap state", 32'(state_dbg), 32'd0);
    chk("wrap 0", 32'(retired), 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the RV32 core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath strobes and muxes, and generates the 2-bit alu_op consumed by the ALU control decoder (00 add, 01 sub/branch compare, 10 use funct fields).
- Handles the memory ready handshake with a wait-state watchdog, and counts retired instructions.

Parameters:
- TIMEOUT, 255, max consecutive wait cycles for mem_ready before fault; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- opcode  input  7  instr[6:0] from the instruction register (valid from DECODE onward)
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  PC load strobe
- ir_write  output  1  instruction register load strobe
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register file write strobe
- mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut
- alu_src_a  output  2  00 = PC, 01 = rs1 reg A, 10 = old-PC reg
- alu_src_b  output  2  00 = rs2 reg B, 01 = const 4, 10 = immediate
- alu_op  output  2  to ALU control decoder
- pc_source  output  1  0 = ALU result, 1 = ALUOut
- illegal_instr  output  1  sticky: unsupported opcode trapped
- mem_fault  output  1  sticky: watchdog expired
- state_dbg  output  4  current state code
- retired  output  CNT_W  retired-instruction count

Behaviour:
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, ALU_WB 7, BRANCH 8, TRAP 15. State register updates on the clk rising edge.
- Reset (rst=1 at edge): state=FETCH, retired=0, illegal_instr=0, mem_fault=0, wait counter=0.
- While rst is high, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0; other outputs follow FETCH decode.
- Reset asserted in any state, including mid-memory access, aborts the access with no further strobes.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write and pc_write are 1 only in a cycle with mem_ready=1; the state then advances to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other -> TRAP, setting illegal_instr
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_read=1, iord=1; on mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; on mem_ready -> FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_source=1, pc_write=zero -> FETCH.
- TRAP: all strobes 0; held until reset.
- Retired counter: increments by 1 on each transition into FETCH from MEM_WB, MEM_WR (on mem_ready), ALU_WB or BRANCH. It wraps modulo 2^CNT_W.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - The wait counter clears on state entry and on mem_ready, and increments on each cycle with mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready=0 -> TRAP, setting mem_fault.
  - mem_ready in that same cycle wins: no fault.

Test Plan:
- add (opcode 0110011), mem_ready tied 1 -> states 0,1,6,7,0 on consecutive cycles; alu_op=10 in EXEC_R; reg_write=1 for exactly one cycle; retired 0->1.
- lw then sw, mem_ready=1 -> lw path 0,1,2,3,4 (5 cycles) with mem_to_reg=1 in MEM_WB; sw path 0,1,2,5 with mem_write=1 and iord=1 for one cycle; retired=2.
- beq with zero=1 -> pc_write=1 and pc_source=1 in BRANCH; repeated with zero=0 -> pc_write stays 0; retired increments in both cases.
- FETCH with mem_ready low 3 cycles, then high -> FETCH held 4 cycles; ir_write and pc_write each high only on the 4th cycle.
- opcode 1111111 at DECODE -> TRAP (state_dbg=15), illegal_instr=1 held; rst pulse -> FETCH, flags 0, retired 0.
- TIMEOUT=4, mem_ready held 0 in MEM_RD -> TRAP after 4 wait cycles, mem_fault=1. Separately, rst asserted mid-MEM_WR -> next cycle FETCH with mem_write=0.
